// File: rtl/ft245_bus_ctrl.sv
// FT245 asynchronous FIFO bus sequencer: drives RD#/WR# and the pad output enable,
// arbitrating the shared data bus between host->FPGA reads and FPGA->host writes.
module ft245_bus_ctrl #(
    parameter int RD_CYCLES        = 4,
    parameter int WR_CYCLES        = 4,
    parameter int SETUP_CYCLES     = 1,
    parameter int PRECHARGE_CYCLES = 4,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ft_rxf_n,
    input  logic       ft_txe_n,
    output logic       ft_rd_n,
    output logic       ft_wr_n,
    input  logic [7:0] ft_d_in,
    output logic [7:0] ft_d_out,
    output logic       ft_d_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int MAX_RW     = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int MAX_SP     = (SETUP_CYCLES > PRECHARGE_CYCLES) ? SETUP_CYCLES : PRECHARGE_CYCLES;
    localparam int MAX_CYCLES = (MAX_RW > MAX_SP) ? MAX_RW : MAX_SP;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_PULSE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        PRECHARGE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_wr_q, last_wr_d;
    logic                   cur_wr_q, cur_wr_d;
    logic [SYNC_STAGES-1:0] rxf_sync_q, txe_sync_q;
    logic                   rd_n_q, wr_n_q, oe_q, rx_valid_q;
    logic [7:0]             d_out_q, rx_data_q;
    logic                   rd_ok, wr_ok, grant_rd, grant_wr;
    logic                   tx_ready_c, rx_capture;

    function automatic logic [CNT_W-1:0] loadCount(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

    // Status pins are asynchronous to clk; reset them to the not-ready level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxf_sync_q <= '1;
            txe_sync_q <= '1;
        end else begin
            rxf_sync_q <= {rxf_sync_q[SYNC_STAGES-2:0], ft_rxf_n};
            txe_sync_q <= {txe_sync_q[SYNC_STAGES-2:0], ft_txe_n};
        end
    end

    assign rd_ok = ~rxf_sync_q[SYNC_STAGES-1] & ~rx_valid_q;
    assign wr_ok = ~txe_sync_q[SYNC_STAGES-1] & tx_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_wr_d  = last_wr_q;
        cur_wr_d   = cur_wr_q;
        grant_rd   = 1'b0;
        grant_wr   = 1'b0;
        tx_ready_c = 1'b0;
        rx_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_ok && wr_ok) begin
                    grant_rd = last_wr_q;
                    grant_wr = ~last_wr_q;
                end else begin
                    grant_rd = rd_ok;
                    grant_wr = wr_ok;
                end
                if (grant_rd) begin
                    state_d  = RD_PULSE;
                    cnt_d    = loadCount(RD_CYCLES);
                    cur_wr_d = 1'b0;
                end else if (grant_wr) begin
                    state_d    = WR_SETUP;
                    cnt_d      = loadCount(SETUP_CYCLES);
                    cur_wr_d   = 1'b1;
                    tx_ready_c = 1'b1;
                end
            end
            RD_PULSE: begin
                if (cnt_q == '0) begin
                    state_d    = PRECHARGE;
                    cnt_d      = loadCount(PRECHARGE_CYCLES);
                    rx_capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = WR_PULSE;
                    cnt_d   = loadCount(WR_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                    cnt_d   = loadCount(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_d = PRECHARGE;
                cnt_d   = loadCount(PRECHARGE_CYCLES);
            end
            PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    last_wr_d = cur_wr_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so each strobe lasts exactly its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b1;
            cur_wr_q   <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            d_out_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            cur_wr_q  <= cur_wr_d;
            rd_n_q    <= (state_d != RD_PULSE);
            wr_n_q    <= (state_d != WR_PULSE);
            oe_q      <= (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
            if (tx_ready_c) begin
                d_out_q <= tx_data;
            end
            if (rx_capture) begin
                rx_data_q  <= ft_d_in;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign ft_rd_n  = rd_n_q;
    assign ft_wr_n  = wr_n_q;
    assign ft_d_oe  = oe_q;
    assign ft_d_out = d_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_c;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ft245_bus_ctrl.sv
// Self-checking bench for ft245_bus_ctrl: an FT245 pin model plus stream-level scoreboards
// that check byte order, strobe widths, arbitration and bus-ownership invariants.
module tb_ft245_bus_ctrl;

    localparam int RD_CYCLES = 4;
    localparam int WR_CYCLES = 4;
    localparam int OE_CYCLES = 1 + 4 + 1;
    localparam int MIN_GAP   = 5;
    localparam logic [7:0] G_RD = 8'h52;
    localparam logic [7:0] G_WR = 8'h57;

    logic       clk = 1'b0;
    logic       rst;
    logic       ft_rxf_n, ft_txe_n, ft_rd_n, ft_wr_n, ft_d_oe;
    logic [7:0] ft_d_in, ft_d_out, rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, busy;

    typedef struct {
        bit         isRead;
        logic [7:0] dataByte;
        int         expLatency;
        int         expRdPulses;
        int         expWrPulses;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] hostSrc[$];
    logic [7:0] txPending[$];
    logic [7:0] rxGot[$];
    logic [7:0] ftGot[$];
    logic [7:0] grantLog[$];
    int hostRdIdx = 0;
    int txAcceptCnt = 0;
    int txIdx = 0;
    int rdPulses = 0;
    int wrPulses = 0;
    int negCount = 0;
    int rxfFallNeg = 0;
    int txeFallNeg = 0;
    int lastRdLat = 0;
    int lastWrLat = 0;

    ft245_bus_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ft_rxf_n (ft_rxf_n),
        .ft_txe_n (ft_txe_n),
        .ft_rd_n  (ft_rd_n),
        .ft_wr_n  (ft_wr_n),
        .ft_d_in  (ft_d_in),
        .ft_d_out (ft_d_out),
        .ft_d_oe  (ft_d_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // FT245 pin model and protocol monitor, sampled on the falling edge.
    initial begin
        int  rdRun, wrRun, oeRun, gapRun;
        logic prevRxf, prevTxe, newRxf;
        rdRun = 0; wrRun = 0; oeRun = 0; gapRun = 100;
        prevRxf = 1'b1; prevTxe = 1'b1;
        ft_rxf_n = 1'b1;
        ft_d_in  = 8'h00;
        forever begin
            @(negedge clk);
            negCount++;
            if (rst) begin
                rdRun = 0; wrRun = 0; oeRun = 0; gapRun = 100;
            end else begin
                checkOutput("oeDuringRd", {31'd0, ft_d_oe & ~ft_rd_n}, 32'd0);
                checkOutput("bothStrobesLow", {31'd0, ~ft_rd_n & ~ft_wr_n}, 32'd0);
                if (!ft_rd_n) begin
                    if (rdRun == 0) begin
                        grantLog.push_back(G_RD);
                        lastRdLat = negCount - rxfFallNeg;
                        checkOutput("gapBeforeRd", {31'd0, gapRun >= MIN_GAP}, 32'd1);
                    end
                    checkOutput("rdWhileRxFull", {31'd0, rx_valid}, 32'd0);
                    rdRun++;
                end else if (rdRun > 0) begin
                    checkOutput("rdPulseLen", rdRun, RD_CYCLES);
                    rdPulses++;
                    hostRdIdx++;
                    rdRun = 0;
                    gapRun = 0;
                end
                if (!ft_wr_n) begin
                    if (wrRun == 0) begin
                        checkOutput("gapBeforeWr", {31'd0, gapRun >= MIN_GAP}, 32'd1);
                    end
                    wrRun++;
                end else if (wrRun > 0) begin
                    checkOutput("wrPulseLen", wrRun, WR_CYCLES);
                    ftGot.push_back(ft_d_out);
                    wrPulses++;
                    wrRun = 0;
                    gapRun = 0;
                end
                if (ft_d_oe) begin
                    if (oeRun == 0) begin
                        grantLog.push_back(G_WR);
                        lastWrLat = negCount - txeFallNeg;
                    end
                    oeRun++;
                end else if (oeRun > 0) begin
                    checkOutput("oeLen", oeRun, OE_CYCLES);
                    oeRun = 0;
                end
                if (ft_rd_n && ft_wr_n) gapRun++;
                if (rx_valid && rx_ready) rxGot.push_back(rx_data);
                if (tx_valid && tx_ready) txAcceptCnt++;
            end
            if (prevTxe && !ft_txe_n) txeFallNeg = negCount;
            prevTxe = ft_txe_n;
            newRxf = !(hostRdIdx < hostSrc.size());
            if (prevRxf && !newRxf) rxfFallNeg = negCount;
            prevRxf = newRxf;
            ft_rxf_n = newRxf;
            ft_d_in  = (hostRdIdx < hostSrc.size()) ? hostSrc[hostRdIdx] : 8'h00;
        end
    end

    // Core-side transmit source: presents queued bytes in order, advancing after each handshake.
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            txIdx = txAcceptCnt;
            if (txIdx < txPending.size()) begin
                tx_valid = 1'b1;
                tx_data  = txPending[txIdx];
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        end
    end

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 200);
        if (n >= 200) checkOutput(name, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int n, rdBefore, wrBefore;
        logic [7:0] got;
        rdBefore = rdPulses;
        wrBefore = wrPulses;
        got = 8'h00;
        n = 0;
        if (v.isRead) begin
            rx_ready = 1'b0;
            hostSrc.push_back(v.dataByte);
            do begin
                @(negedge clk);
                n++;
            end while (rx_valid !== 1'b1 && n < 60);
            if (n >= 60) checkOutput($sformatf("vec%0d_rdTimeout", idx), 32'd0, 32'd1);
            got = rx_data;
            @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
        end else begin
            txPending.push_back(v.dataByte);
            repeat (3) @(posedge clk);
            #1 ft_txe_n = 1'b0;
            do begin
                @(negedge clk);
                n++;
            end while (wrPulses == wrBefore && n < 60);
            if (n >= 60) checkOutput($sformatf("vec%0d_wrTimeout", idx), 32'd0, 32'd1);
            if (ftGot.size() > 0) got = ftGot[$];
            @(posedge clk);
            #1 ft_txe_n = 1'b1;
        end
        waitIdle($sformatf("vec%0d_idleTimeout", idx));
        repeat (3) @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d_data", idx), {24'd0, got}, {24'd0, v.dataByte});
        checkOutput($sformatf("vec%0d_latency", idx), v.isRead ? lastRdLat : lastWrLat, v.expLatency);
        checkOutput($sformatf("vec%0d_rdPulses", idx), rdPulses - rdBefore, v.expRdPulses);
        checkOutput($sformatf("vec%0d_wrPulses", idx), wrPulses - wrBefore, v.expWrPulses);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vectors[6];
        logic [7:0] expOrder[4];
        int n, base, rdBefore, ftBefore;

        vectors[0] = '{1'b1, 8'hA5, 3, 1, 0};
        vectors[1] = '{1'b0, 8'h3C, 3, 0, 1};
        vectors[2] = '{1'b1, 8'h00, 3, 1, 0};
        vectors[3] = '{1'b0, 8'hFF, 3, 0, 1};
        vectors[4] = '{1'b1, 8'hFF, 3, 1, 0};
        vectors[5] = '{1'b0, 8'h00, 3, 0, 1};
        expOrder = '{G_RD, G_WR, G_RD, G_WR};

        // Reset held with both sides requesting, then released: grants must alternate from RD.
        rst      = 1'b1;
        ft_txe_n = 1'b0;
        rx_ready = 1'b0;
        hostSrc.push_back(8'h11);
        hostSrc.push_back(8'h22);
        txPending.push_back(8'h81);
        txPending.push_back(8'h82);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRdN", {31'd0, ft_rd_n}, 32'd1);
        checkOutput("rstWrN", {31'd0, ft_wr_n}, 32'd1);
        checkOutput("rstOe", {31'd0, ft_d_oe}, 32'd0);
        checkOutput("rstRxValid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rstTxReady", {31'd0, tx_ready}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rx_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((wrPulses < 2 || rdPulses < 2 || busy !== 1'b0) && n < 300);
        if (n >= 300) checkOutput("alternateTimeout", 32'd0, 32'd1);
        checkOutput("grantCount", grantLog.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grantLog.size())
                checkOutput($sformatf("grantOrder%0d", i), {24'd0, grantLog[i]}, {24'd0, expOrder[i]});
        end
        @(posedge clk);
        #1 ft_txe_n = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) applyStimulus(vectors[i], i);

        // Randomised traffic in both directions, judged by stream order at the end.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0 && (hostSrc.size() - hostRdIdx) < 3)
                hostSrc.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0 && (txPending.size() - txIdx) < 3)
                txPending.push_back(8'($urandom_range(0, 255)));
            ft_txe_n = ($urandom_range(0, 3) == 0);
            rx_ready = 1'($urandom_range(0, 1));
        end
        ft_txe_n = 1'b0;
        rx_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rxGot.size() != hostSrc.size() || ftGot.size() != txPending.size()
                    || busy !== 1'b0) && n < 1000);
        if (n >= 1000) checkOutput("drainTimeout", 32'd0, 32'd1);
        checkOutput("rxStreamLen", rxGot.size(), hostSrc.size());
        checkOutput("txStreamLen", ftGot.size(), txPending.size());
        for (int i = 0; i < rxGot.size() && i < hostSrc.size(); i++)
            checkOutput($sformatf("rxByte%0d", i), {24'd0, rxGot[i]}, {24'd0, hostSrc[i]});
        for (int i = 0; i < ftGot.size() && i < txPending.size(); i++)
            checkOutput($sformatf("txByte%0d", i), {24'd0, ftGot[i]}, {24'd0, txPending[i]});
        @(posedge clk);
        #1 ft_txe_n = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // A full RX buffer must block further reads until the consumer accepts.
        base = rxGot.size();
        rdBefore = rdPulses;
        hostSrc.push_back(8'h5A);
        hostSrc.push_back(8'hC3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_valid !== 1'b1 && n < 60);
        if (n >= 60) checkOutput("fullRdTimeout", 32'd0, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("noReadWhileFull", rdPulses - rdBefore, 32'd1);
        checkOutput("heldRxData", {24'd0, rx_data}, 32'h5A);
        rx_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rxGot.size() < base + 2 || busy !== 1'b0) && n < 100);
        if (n >= 100) checkOutput("resumeTimeout", 32'd0, 32'd1);
        checkOutput("resumeRdPulses", rdPulses - rdBefore, 32'd2);
        if (rxGot.size() >= base + 2) begin
            checkOutput("resumeByte0", {24'd0, rxGot[base]}, 32'h5A);
            checkOutput("resumeByte1", {24'd0, rxGot[base + 1]}, 32'hC3);
        end
        @(posedge clk);
        #1 rx_ready = 1'b0;

        // Reset during the WR# pulse drops the byte and releases the bus on the next edge.
        ftBefore = ftGot.size();
        txPending.push_back(8'h99);
        ft_txe_n = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ft_wr_n !== 1'b0 && n < 60);
        if (n >= 60) checkOutput("abortWrTimeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abortWrN", {31'd0, ft_wr_n}, 32'd1);
        checkOutput("abortOe", {31'd0, ft_d_oe}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        txPending.push_back(8'h77);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready !== 1'b1 && n < 60);
        checkOutput("txReadyAfterAbort", {31'd0, tx_ready}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ftGot.size() == ftBefore || busy !== 1'b0) && n < 100);
        if (n >= 100) checkOutput("postAbortTimeout", 32'd0, 32'd1);
        checkOutput("postAbortCount", ftGot.size() - ftBefore, 32'd1);
        if (ftGot.size() > 0) checkOutput("postAbortByte", {24'd0, ftGot[$]}, 32'h77);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
